// File: rtl/memcpy_rd_scheduler_if.sv
// Bus between the memcpy CSR/CCI-P glue and the read scheduler: job config,
// flow-control inputs, read request strobe and job status.
interface memcpy_rd_scheduler_if #(
   parameter int ADDR_W  = 42,
   parameter int CNT_W   = 32,
   parameter int MDATA_W = 16
);
   logic               start;
   logic               abort;
   logic [ADDR_W-1:0]  cfg_src_addr;
   logic [CNT_W-1:0]   cfg_num_lines;
   logic [CNT_W-1:0]   cfg_window;
   logic               c0_alm_full;
   logic               c1_alm_full;
   logic               wr_rsp_valid;
   logic               rd_req_valid;
   logic [ADDR_W-1:0]  rd_req_addr;
   logic [MDATA_W-1:0] rd_req_mdata;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   issued_cnt;
   logic [CNT_W-1:0]   retired_cnt;
   logic [63:0]        cycle_cnt;
   logic               err_underflow;

   modport master (
      output start, abort, cfg_src_addr, cfg_num_lines, cfg_window,
             c0_alm_full, c1_alm_full, wr_rsp_valid,
      input  rd_req_valid, rd_req_addr, rd_req_mdata, busy, done,
             issued_cnt, retired_cnt, cycle_cnt, err_underflow
   );

   modport slave (
      input  start, abort, cfg_src_addr, cfg_num_lines, cfg_window,
             c0_alm_full, c1_alm_full, wr_rsp_valid,
      output rd_req_valid, rd_req_addr, rd_req_mdata, busy, done,
             issued_cnt, retired_cnt, cycle_cnt, err_underflow
   );
endinterface

// File: rtl/memcpy_rd_scheduler.sv
// Read-side sequencer for a CCI-P memcpy job: issues one RDLINE per cycle,
// throttled by almost-full and by the window of reads not yet write-acked.
module memcpy_rd_scheduler #(
   parameter int ADDR_W  = 42,
   parameter int CNT_W   = 32,
   parameter int MDATA_W = 16
) (
   input logic                clk,
   input logic                reset,
   memcpy_rd_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, next_state;
   logic [ADDR_W-1:0]  src_q;
   logic [CNT_W-1:0]   num_lines_q;
   logic [CNT_W-1:0]   window_q;
   logic [CNT_W-1:0]   target_q;
   logic [CNT_W-1:0]   issued_q;
   logic [CNT_W-1:0]   retired_q;
   logic [63:0]        cycle_q;
   logic               err_q;
   logic               req_valid_q;
   logic [ADDR_W-1:0]  req_addr_q;
   logic [MDATA_W-1:0] req_mdata_q;

   logic [CNT_W-1:0]   outstanding;
   logic               accept_start;
   logic               issue_ok;
   logic               do_issue;
   logic               active;
   logic               rsp_count;
   logic               rsp_underflow;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (accept_start) next_state = RUN;
         RUN: begin
            if (bus.abort)
               next_state = DRAIN;
            else if (do_issue && (issued_q + CNT_W'(1) == num_lines_q))
               next_state = DRAIN;
         end
         DRAIN: if (retired_q == target_q) next_state = DONE;
         DONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Abort wins over a same-cycle issue so the drain target is exactly what went out.
   always_comb begin
      bus.busy      = (state != IDLE);
      bus.done      = (state == DONE);
      active        = (state == RUN) || (state == DRAIN);
      accept_start  = (state == IDLE) && bus.start &&
                      (bus.cfg_num_lines != '0) && (bus.cfg_window != '0);
      outstanding   = issued_q - retired_q;
      issue_ok      = (state == RUN) && !bus.c0_alm_full && !bus.c1_alm_full &&
                      (issued_q < num_lines_q) && (outstanding < window_q);
      do_issue      = issue_ok && !bus.abort;
      rsp_count     = active && bus.wr_rsp_valid && (outstanding != '0);
      rsp_underflow = active && bus.wr_rsp_valid && (outstanding == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q       <= '0;
         num_lines_q <= '0;
         window_q    <= '0;
         target_q    <= '0;
         issued_q    <= '0;
         retired_q   <= '0;
         cycle_q     <= '0;
         err_q       <= 1'b0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_mdata_q <= '0;
      end else begin
         req_valid_q <= do_issue;
         if (do_issue) begin
            req_addr_q  <= src_q + ADDR_W'(issued_q);
            req_mdata_q <= MDATA_W'(issued_q);
         end
         if (accept_start) begin
            src_q       <= bus.cfg_src_addr;
            num_lines_q <= bus.cfg_num_lines;
            window_q    <= bus.cfg_window;
            target_q    <= bus.cfg_num_lines;
            issued_q    <= '0;
            retired_q   <= '0;
            cycle_q     <= '0;
            err_q       <= 1'b0;
         end else begin
            if (do_issue)                     issued_q  <= issued_q + CNT_W'(1);
            if (rsp_count)                    retired_q <= retired_q + CNT_W'(1);
            if (rsp_underflow)                err_q     <= 1'b1;
            if ((state == RUN) && bus.abort)  target_q  <= issued_q;
            if (active && (cycle_q != '1))    cycle_q   <= cycle_q + 64'd1;
         end
      end
   end

   assign bus.rd_req_valid  = req_valid_q;
   assign bus.rd_req_addr   = req_addr_q;
   assign bus.rd_req_mdata  = req_mdata_q;
   assign bus.issued_cnt    = issued_q;
   assign bus.retired_cnt   = retired_q;
   assign bus.cycle_cnt     = cycle_q;
   assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_memcpy_rd_scheduler.sv
// Scoreboard bench for memcpy_rd_scheduler: expected requests are queued at job
// start and popped as the DUT issues them; responses come from a delay model or by hand.
module tb_memcpy_rd_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b1;

   memcpy_rd_scheduler_if #(.ADDR_W(42), .CNT_W(32), .MDATA_W(16)) bus ();

   memcpy_rd_scheduler #(.ADDR_W(42), .CNT_W(32), .MDATA_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit autoRsp = 1'b0;
   int rspDelay = 1;
   int expCycles = 0;
   int donePulses = 0;
   int reqSeen = 0;
   logic [41:0] expAddr[$];
   logic [15:0] expMdata[$];
   int rspDue[$];

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // One clock: sample #1 after the edge, score any request, drive the response model.
   task automatic tick();
      bit countThis;
      countThis = bus.busy && !bus.done;
      @(posedge clk);
      #1;
      cyc++;
      if (countThis) expCycles++;
      if (bus.done) donePulses++;
      if (bus.rd_req_valid) begin
         reqSeen++;
         if (expAddr.size() == 0) begin
            checkOutput("unexpected_req", 64'd1, 64'd0);
         end else begin
            checkOutput("rd_req_addr", 64'(bus.rd_req_addr), 64'(expAddr.pop_front()));
            checkOutput("rd_req_mdata", 64'(bus.rd_req_mdata), 64'(expMdata.pop_front()));
         end
         if (autoRsp) rspDue.push_back(cyc + rspDelay);
      end
      if (autoRsp) begin
         if (rspDue.size() > 0 && rspDue[0] <= cyc) begin
            bus.wr_rsp_valid = 1'b1;
            void'(rspDue.pop_front());
         end else begin
            bus.wr_rsp_valid = 1'b0;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic applyStimulus(input logic [41:0] src, input int unsigned lines,
                                input int unsigned window);
      logic [41:0] a;
      if (lines != 0 && window != 0 && !bus.busy) begin
         expAddr.delete();
         expMdata.delete();
         rspDue.delete();
         for (int unsigned i = 0; i < lines; i++) begin
            a = src + 42'(i);
            expAddr.push_back(a);
            expMdata.push_back(16'(i));
         end
         expCycles = 0;
         donePulses = 0;
         reqSeen = 0;
      end
      bus.cfg_src_addr  = src;
      bus.cfg_num_lines = lines;
      bus.cfg_window    = window;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic retireOne();
      bus.wr_rsp_valid = 1'b1;
      tick();
      bus.wr_rsp_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n;
      n = 0;
      while (!bus.done && n < budget) begin
         tick();
         n++;
      end
      checkOutput({tag, "_done_seen"}, 64'(bus.done), 64'd1);
      tick();
      checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      checkOutput({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
      checkOutput({tag, "_done_count"}, 64'(donePulses), 64'd1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.cfg_src_addr = '0;
      bus.cfg_num_lines = '0;
      bus.cfg_window = '0;
      bus.c0_alm_full = 1'b0;
      bus.c1_alm_full = 1'b0;
      bus.wr_rsp_valid = 1'b0;

      #12;
      checkOutput("rst_rd_req_valid", 64'(bus.rd_req_valid), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_done", 64'(bus.done), 64'd0);
      checkOutput("rst_issued", 64'(bus.issued_cnt), 64'd0);
      checkOutput("rst_cycle", bus.cycle_cnt, 64'd0);
      checkOutput("rst_addr", 64'(bus.rd_req_addr), 64'd0);
      checkOutput("rst_err", 64'(bus.err_underflow), 64'd0);
      #1 reset = 1'b0;
      tick();

      // Responses in IDLE are ignored entirely.
      retireOne();
      checkOutput("idle_rsp_err", 64'(bus.err_underflow), 64'd0);
      checkOutput("idle_rsp_retired", 64'(bus.retired_cnt), 64'd0);

      $display("[TB] basic job");
      autoRsp = 1'b1;
      rspDelay = 5;
      applyStimulus(42'h1000, 4, 64);
      checkOutput("t1_busy", 64'(bus.busy), 64'd1);
      waitDone("t1", 200);
      checkOutput("t1_issued", 64'(bus.issued_cnt), 64'd4);
      checkOutput("t1_retired", 64'(bus.retired_cnt), 64'd4);
      checkOutput("t1_cycle_cnt", bus.cycle_cnt, 64'(expCycles));
      checkOutput("t1_queue_empty", 64'(expAddr.size()), 64'd0);
      checkOutput("t1_err", 64'(bus.err_underflow), 64'd0);

      $display("[TB] window throttle");
      autoRsp = 1'b0;
      bus.wr_rsp_valid = 1'b0;
      applyStimulus(42'h2000, 10, 2);
      ticks(8);
      checkOutput("t2_issued_stall", 64'(bus.issued_cnt), 64'd2);
      checkOutput("t2_req_seen", 64'(reqSeen), 64'd2);
      for (int k = 1; k <= 9; k++) begin
         retireOne();
         ticks(3);
         checkOutput("t2_issued_step", 64'(bus.issued_cnt), 64'((k + 2 > 10) ? 10 : k + 2));
         checkOutput("t2_retired_step", 64'(bus.retired_cnt), 64'(k));
      end
      checkOutput("t2_no_done_early", 64'(donePulses), 64'd0);
      retireOne();
      waitDone("t2", 20);
      checkOutput("t2_retired", 64'(bus.retired_cnt), 64'd10);
      checkOutput("t2_queue_empty", 64'(expAddr.size()), 64'd0);

      $display("[TB] almost-full stall");
      autoRsp = 1'b1;
      rspDelay = 3;
      applyStimulus(42'h3000, 40, 64);
      ticks(6);
      bus.c0_alm_full = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput("t3_req_during_almfull", 64'(bus.rd_req_valid), 64'd0);
      end
      bus.c0_alm_full = 1'b0;
      tick();
      checkOutput("t3_resume", 64'(bus.rd_req_valid), 64'd1);
      bus.c1_alm_full = 1'b1;
      tick();
      tick();
      checkOutput("t3_req_during_c1", 64'(bus.rd_req_valid), 64'd0);
      bus.c1_alm_full = 1'b0;
      waitDone("t3", 300);
      checkOutput("t3_issued", 64'(bus.issued_cnt), 64'd40);
      checkOutput("t3_queue_empty", 64'(expAddr.size()), 64'd0);

      $display("[TB] mdata and address wrap");
      rspDelay = 1;
      applyStimulus(42'h3FF_FFFF_FFF0, 65540, 32'hFFFF_FFFF);
      waitDone("t4", 70000);
      checkOutput("t4_issued", 64'(bus.issued_cnt), 64'd65540);
      checkOutput("t4_retired", 64'(bus.retired_cnt), 64'd65540);
      checkOutput("t4_last_mdata", 64'(bus.rd_req_mdata), 64'h3);
      checkOutput("t4_queue_empty", 64'(expAddr.size()), 64'd0);

      $display("[TB] abort");
      autoRsp = 1'b0;
      bus.wr_rsp_valid = 1'b0;
      applyStimulus(42'h5000, 10, 3);
      ticks(5);
      checkOutput("t5_issued_pre", 64'(bus.issued_cnt), 64'd3);
      retireOne();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checkOutput("t5_abort_suppress", 64'(bus.rd_req_valid), 64'd0);
      checkOutput("t5_issued_abort", 64'(bus.issued_cnt), 64'd3);
      ticks(4);
      checkOutput("t5_req_seen", 64'(reqSeen), 64'd3);
      retireOne();
      ticks(2);
      checkOutput("t5_no_done_early", 64'(donePulses), 64'd0);
      checkOutput("t5_busy_drain", 64'(bus.busy), 64'd1);
      retireOne();
      waitDone("t5", 20);
      checkOutput("t5_issued", 64'(bus.issued_cnt), 64'd3);
      checkOutput("t5_retired", 64'(bus.retired_cnt), 64'd3);

      $display("[TB] underflow and rejected starts");
      bus.c0_alm_full = 1'b1;
      applyStimulus(42'h6000, 5, 4);
      ticks(2);
      retireOne();
      checkOutput("t6_err", 64'(bus.err_underflow), 64'd1);
      checkOutput("t6_retired", 64'(bus.retired_cnt), 64'd0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      waitDone("t6", 20);
      checkOutput("t6_err_sticky", 64'(bus.err_underflow), 64'd1);
      bus.c0_alm_full = 1'b0;
      applyStimulus(42'h7000, 0, 4);
      ticks(3);
      checkOutput("t6_zero_lines_idle", 64'(bus.busy), 64'd0);
      applyStimulus(42'h7000, 4, 0);
      ticks(3);
      checkOutput("t6_zero_window_idle", 64'(bus.busy), 64'd0);
      checkOutput("t6_err_kept", 64'(bus.err_underflow), 64'd1);
      checkOutput("t6_req_seen", 64'(reqSeen), 64'd0);

      $display("[TB] reset mid-run");
      autoRsp = 1'b1;
      rspDelay = 2;
      applyStimulus(42'h8000, 20, 64);
      ticks(5);
      checkOutput("t7_running", 64'(bus.rd_req_valid), 64'd1);
      #3 reset = 1'b1;
      #1;
      checkOutput("t7_rd_req_valid", 64'(bus.rd_req_valid), 64'd0);
      checkOutput("t7_busy", 64'(bus.busy), 64'd0);
      checkOutput("t7_issued", 64'(bus.issued_cnt), 64'd0);
      checkOutput("t7_retired", 64'(bus.retired_cnt), 64'd0);
      checkOutput("t7_cycle", bus.cycle_cnt, 64'd0);
      checkOutput("t7_addr", 64'(bus.rd_req_addr), 64'd0);
      autoRsp = 1'b0;
      bus.wr_rsp_valid = 1'b0;
      expAddr.delete();
      expMdata.delete();
      rspDue.delete();
      #2 reset = 1'b0;
      ticks(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
